// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// Optional feature macro: MULT_DIV_UNSIGNED_EN (enables multu/divu decoding).
package mult_div_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ITER  = 32;
  localparam int ITER_LAST = DEF_ITER - 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIX,
    DONE
  } state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_MULTU = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Two's complement magnitude; |0x80000000| stays 0x80000000 read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request/result bundle between the main control unit and the mult/div sequencer.
interface mult_div_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  // Control unit side: issues requests, observes status and HI/LO.
  modport master (
    output Start, Op, A, B,
    input  Busy, Done, DivZero, Hi, Lo
  );

  // Sequencer side.
  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, DivZero, Hi, Lo
  );

endinterface

// File: rtl/mult_div_ctrl_step.sv
// One iteration of the shift-add multiply or restoring divide loop.
// Multiply: acc = {partial product, remaining multiplier bits}, shifts right.
// Divide:   acc = {partial remainder, dividend/quotient bits}, shifts left.
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_msb;

  // A kept trial difference is below the divisor, so bit WIDTH is always zero there.
  assign unused_trial_msb = trial[WIDTH];

  // Select the multiply or divide update of the accumulator.
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Shifted remainder is WIDTH+1 bits wide; one extra bit holds the borrow.
    trial = {1'b0, acc_i[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_i};
    if (div_i) begin
      if (!trial[WIDTH+1]) begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative mult/div/multu/divu sequencer with HI/LO result registers.
// Optional feature macro: MULT_DIV_UNSIGNED_EN. When undefined, Op[1] is
// ignored and every operation runs as signed mult/div with the same latency.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = DEF_ITER
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(ITER) + 1;

  // The datapath and the shared iteration constant assume 32-bit operands.
  if (WIDTH != 32 || ITER != WIDTH) begin : g_bad_cfg
    $error("mult_div_ctrl supports only WIDTH == ITER == 32");
  end

  state_t             state_q;
  logic               div_q;
  logic               uns_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               divzero_q;

  logic               start_div_d;
  logic               start_uns_d;
  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic [2*WIDTH-1:0] acc_step_d;
  logic [2*WIDTH-1:0] prod_fix_d;
  logic [WIDTH-1:0]   quot_fix_d;
  logic [WIDTH-1:0]   rem_fix_d;

  // Decode the requested operation at the request port.
  always_comb begin
    start_div_d = 1'b0;
    case (bus.Op)
      OP_MULT:  start_div_d = 1'b0;
      OP_DIV:   start_div_d = 1'b1;
      OP_MULTU: start_div_d = 1'b0;
      OP_DIVU:  start_div_d = 1'b1;
      default:  start_div_d = 1'b0;
    endcase
`ifdef MULT_DIV_UNSIGNED_EN
    start_uns_d = (bus.Op == OP_MULTU) || (bus.Op == OP_DIVU);
`else
    start_uns_d = 1'b0;
`endif
  end

  // Operand magnitudes for the work registers; unsigned ops use raw values.
  always_comb begin
    mag_a_d = uns_q ? a_q : abs32(a_q);
    mag_b_d = uns_q ? b_q : abs32(b_q);
  end

  mult_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (div_q),
    .acc_o  (acc_step_d)
  );

  // Sign fix-up: quotient/product follow sign(A)^sign(B), remainder follows A.
  always_comb begin
    prod_fix_d = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
    quot_fix_d = (sign_a_q ^ sign_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix_d  = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Sequencer FSM with registered status outputs and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= 1'b0;
      uns_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            if (start_div_d && (bus.B == '0)) begin
              // Divide by zero short-circuits straight to completion.
              state_q   <= DONE;
              done_q    <= 1'b1;
              divzero_q <= 1'b1;
            end else begin
              div_q   <= start_div_d;
              uns_q   <= start_uns_d;
              a_q     <= bus.A;
              b_q     <= bus.B;
              busy_q  <= 1'b1;
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          sign_a_q <= !uns_q && a_q[WIDTH-1];
          sign_b_q <= !uns_q && b_q[WIDTH-1];
          // Low half carries the multiplier (mult) or dividend (div).
          acc_q    <= {{WIDTH{1'b0}}, div_q ? mag_a_d : mag_b_d};
          opnd_q   <= div_q ? mag_b_d : mag_a_d;
          cnt_q    <= '0;
          state_q  <= RUN;
        end
        RUN: begin
          acc_q <= acc_step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER_LAST)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (div_q) begin
            hi_q <= rem_fix_d;
            lo_q <= quot_fix_d;
          end else begin
            hi_q <= prod_fix_d[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix_d[WIDTH-1:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q    <= 1'b0;
          divzero_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = divzero_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: latency, signed/unsigned results,
// divide-by-zero, ignored re-start and mid-run reset.
module tb_mult_div_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   done_k;
  int   busy_n;
  int   done_seen;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_ctrl_if #(.WIDTH(32)) bus ();

  mult_div_ctrl #(
    .WIDTH (32),
    .ITER  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one request; k counts posedges after the Start-sampling edge E0,
  // sampled at the following negedge. Optionally re-pulse Start at rep_k.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int rep_k, output int dk, output int bn);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.Start = 1'b0;
    dk = -1;
    bn = 0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      if (k == rep_k) begin
        bus.Start = 1'b1;
        bus.Op    = 2'b01;
        bus.A     = 32'd3;
        bus.B     = 32'd3;
      end else if (k == rep_k + 1) begin
        bus.Start = 1'b0;
      end
      if (bus.Busy) bn++;
      if (bus.Done) begin
        dk = k;
        break;
      end
    end
    bus.Start = 1'b0;
    $display("op=%b A=%h B=%h -> Hi=%h Lo=%h DivZero=%b done_at=%0d busy=%0d",
             op, a, b, bus.Hi, bus.Lo, bus.DivZero, dk, bn);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_divzero", 32'(bus.DivZero), 32'd0);
    chk("rst_hi", bus.Hi, 32'd0);
    chk("rst_lo", bus.Lo, 32'd0);

    // mult 7 * -3 = -21
    do_op(2'b00, 32'd7, 32'hFFFF_FFFD, -10, done_k, busy_n);
    chk("mult_latency", 32'(done_k), 32'd34);
    chk("mult_busy_cycles", 32'(busy_n), 32'd34);
    chk("mult_hi", bus.Hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.Lo, 32'hFFFF_FFEB);
    chk("mult_divzero", 32'(bus.DivZero), 32'd0);
    @(negedge clk);
    chk("mult_done_one_cycle", 32'(bus.Done), 32'd0);

    // mult -5 * -6 = 30
    do_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, -10, done_k, busy_n);
    chk("mult_negneg_hi", bus.Hi, 32'd0);
    chk("mult_negneg_lo", bus.Lo, 32'h0000_001E);

    // div -7 / 2: q=-3, r=-1
    do_op(2'b01, 32'hFFFF_FFF9, 32'd2, -10, done_k, busy_n);
    chk("div_latency", 32'(done_k), 32'd34);
    chk("div_lo", bus.Lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.Hi, 32'hFFFF_FFFF);

    // div 100 / -7: q=-14, r=2
    do_op(2'b01, 32'd100, 32'hFFFF_FFF9, -10, done_k, busy_n);
    chk("div_posneg_lo", bus.Lo, 32'hFFFF_FFF2);
    chk("div_posneg_hi", bus.Hi, 32'd2);

    // div 0x80000000 / -1 wraps, no flag
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, -10, done_k, busy_n);
    chk("div_wrap_lo", bus.Lo, 32'h8000_0000);
    chk("div_wrap_hi", bus.Hi, 32'd0);
    chk("div_wrap_divzero", 32'(bus.DivZero), 32'd0);

    // Preload HI/LO, then divide by zero
    do_op(2'b00, 32'h0001_2345, 32'h0000_0010, -10, done_k, busy_n);
    chk("preload_lo", bus.Lo, 32'h0012_3450);
    do_op(2'b01, 32'd5, 32'd0, -10, done_k, busy_n);
    chk("dz_latency", 32'(done_k), 32'd0);
    chk("dz_flag", 32'(bus.DivZero), 32'd1);
    chk("dz_busy_cycles", 32'(busy_n), 32'd0);
    chk("dz_hi_kept", bus.Hi, 32'd0);
    chk("dz_lo_kept", bus.Lo, 32'h0012_3450);
    @(negedge clk);
    chk("dz_flag_cleared", 32'(bus.DivZero), 32'd0);
    chk("dz_done_cleared", 32'(bus.Done), 32'd0);

    // multu 0xFFFFFFFF * 0xFFFFFFFF
`ifdef MULT_DIV_UNSIGNED_EN
    exp_hi = 32'hFFFF_FFFE;
    exp_lo = 32'h0000_0001;
`else
    exp_hi = 32'h0000_0000;
    exp_lo = 32'h0000_0001;
`endif
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10, done_k, busy_n);
    chk("multu_latency", 32'(done_k), 32'd34);
    chk("multu_hi", bus.Hi, exp_hi);
    chk("multu_lo", bus.Lo, exp_lo);

    // divu 0xFFFFFFFF / 2
`ifdef MULT_DIV_UNSIGNED_EN
    exp_hi = 32'h0000_0001;
    exp_lo = 32'h7FFF_FFFF;
`else
    exp_hi = 32'hFFFF_FFFF;
    exp_lo = 32'h0000_0000;
`endif
    do_op(2'b11, 32'hFFFF_FFFF, 32'd2, -10, done_k, busy_n);
    chk("divu_hi", bus.Hi, exp_hi);
    chk("divu_lo", bus.Lo, exp_lo);

    // Start re-pulsed mid-run with different operands is ignored
    do_op(2'b00, 32'h0001_0000, 32'h0001_0000, 5, done_k, busy_n);
    chk("repulse_latency", 32'(done_k), 32'd34);
    chk("repulse_hi", bus.Hi, 32'h0000_0001);
    chk("repulse_lo", bus.Lo, 32'h0000_0000);
    @(negedge clk);
    chk("repulse_no_restart", 32'(bus.Busy), 32'd0);

    // Reset at RUN cycle 10 aborts the operation
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = 2'b00;
    bus.A     = 32'd7;
    bus.B     = 32'hFFFF_FFFD;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_busy_before", 32'(bus.Busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(bus.Busy), 32'd0);
    chk("rst_mid_hi", bus.Hi, 32'd0);
    chk("rst_mid_lo", bus.Lo, 32'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.Done) done_seen++;
    end
    chk("rst_mid_no_done", 32'(done_seen), 32'd0);
    $display("op=00 A=00000007 B=fffffffd reset mid-run -> Hi=%h Lo=%h done_pulses=%0d",
             bus.Hi, bus.Lo, done_seen);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Iterative multiply/divide sequencer for the multicycle MIPS datapath. It serves the mult, div, multu and divu instructions. It latches two 32-bit register operands on a start pulse from the main control unit, runs a 32-step shift-add (multiply) or restoring (divide) loop, and writes the 64-bit result into its HI/LO registers. The main control FSM waits on `Done` before returning to Fetch. A divide-by-zero is flagged so the control unit can branch to its exception states.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `ITER`, default 32: loop iterations. Must equal `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `Start`  in  1  request pulse from control; sampled only in IDLE.
- `Op`  in  2  operation: 00 mult, 01 div, 10 multu, 11 divu.
- `A`  in  32  rs operand (multiplicand / dividend).
- `B`  in  32  rt operand (multiplier / divisor).
- `Busy`  out  1  high in every state except IDLE and DONE.
- `Done`  out  1  one-cycle completion pulse.
- `DivZero`  out  1  high together with `Done` when a div/divu has B==0.
- `Hi`  out  32  HI register: product[63:32] or remainder.
- `Lo`  out  32  LO register: product[31:0] or quotient.

## Operation
- Reset values: `Busy`=0, `Done`=0, `DivZero`=0, `Hi`=0, `Lo`=0, state=IDLE, iteration counter=0.

States:
- **IDLE**
  - If `Start`=1 and this is a div/divu with B==0: go to DONE with `DivZero`=1. `Hi`/`Lo` stay unchanged.
  - If `Start`=1 otherwise: latch `Op`, A and B, then go to LOAD.
- **LOAD**
  - Record the operand signs, but only for signed ops.
  - Load the magnitudes |A| and |B| into the work registers. Use the raw operands for unsigned ops.
  - Clear the 64-bit accumulator and set counter=0.
  - Go to RUN.
- **RUN**
  - One step per cycle.
  - Multiply: if multiplier LSB=1, add the multiplicand into the upper half, then shift right by 1.
  - Divide: shift the remainder/quotient pair left by 1. Trial-subtract the divisor; if the result is non-negative, keep it and set the quotient LSB.
  - Counter increments each cycle. After the step with counter==ITER-1, go to FIX.
- **FIX**
  - Signed multiply: negate the 64-bit product if sign(A)≠sign(B).
  - Signed divide: negate the quotient if the signs differ; negate the remainder if A<0.
  - Write `Hi`/`Lo`, then go to DONE.
- **DONE**
  - `Done`=1 for exactly one cycle, then go to IDLE.
  - `DivZero` is cleared when leaving DONE.

Arithmetic rules:
- Quotient truncates toward zero; the remainder takes the dividend's sign.
- 0x80000000 / 0xFFFFFFFF (signed) wraps: Lo=0x80000000, Hi=0. No flag is raised.
- The |0x80000000| magnitude is handled as unsigned 32-bit, so there is no overflow.

Boundary conditions:
- `Start` while not in IDLE is ignored; the operands in flight are unaffected.
- `Start` during the DONE cycle is ignored. It is accepted on the next cycle (IDLE).
- `reset` mid-operation aborts the operation: IDLE, `Hi`=`Lo`=0, and no `Done` pulse.
- `Hi`/`Lo` hold their value between operations. They change only in FIX or on reset.

## Timing
- Start sampled at edge E0 → LOAD after E0 → RUN after E1 → 32 RUN cycles (E2..E33) → FIX after E33 → `Hi`/`Lo` valid and `Done`=1 in the cycle after E34.
- Normal latency is 34 cycles from the Start-sampling edge to `Done`.
- Divide-by-zero latency is 1 cycle: `Done`=`DivZero`=1 in the cycle after E0.
- `Busy` is high from the cycle after E0 through the FIX cycle.

## Configuration
- Macro: `MULT_DIV_UNSIGNED_EN`.
- Defined: `Op`[1]=1 selects unsigned multu/divu. There is no sign capture or FIX negation, and the operands are used raw.
- Undefined: `Op`[1] is ignored and every operation executes as signed mult/div. Latency is identical in both builds.

## Structure
- Shared package `mult_div_pkg` holds:
  - the state enum (IDLE, LOAD, RUN, FIX, DONE);
  - the `Op` encodings (OP_MULT, OP_DIV, OP_MULTU, OP_DIVU);
  - `ITER_LAST` = ITER-1.
- One sub-module, `mult_div_step`: combinational single-iteration datapath. It takes the accumulator, operand and mode, and returns the next accumulator. The FSM, counter, sign fix-up and HI/LO registers stay in `mult_div_ctrl`.

## Test plan
- mult: A=7, B=0xFFFFFFFD (-3) → `Done` in the cycle after E34; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; `Busy` high for 34 cycles.
- div: A=0xFFFFFFF9 (-7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Also A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- div by zero: A=5, B=0, with Hi/Lo preloaded by a previous mult → `Done`=`DivZero`=1 in the cycle after E0; Hi/Lo unchanged; `Busy` never high.
- multu 0xFFFFFFFF × 0xFFFFFFFF → with macro: Hi=0xFFFFFFFE, Lo=0x00000001. Without macro: Hi=0, Lo=1.
- Start re-pulsed at cycle 5 with different operands → ignored; the first result completes unchanged.
- `reset` at cycle 10 of RUN → next cycle `Busy`=0, Hi=Lo=0; no `Done` pulse within 40 cycles.
